// File: rtl/sync_test_sequencer.sv
// Run controller for the CDC synchronizer test datapath: walks enabled channels,
// drives a rotated word plus stimulus pulses, waits, samples obs and tallies mismatches.
module sync_test_sequencer #(
  parameter int N     = 8,
  parameter int CNT_W = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [4:0]       ch_mask,
  input  logic [CNT_W-1:0] settle,
  input  logic [N-1:0]     pattern,
  input  logic [N-1:0]     obs,
  output logic [2:0]       sel,
  output logic [N-1:0]     data_drv,
  output logic             trigger,
  output logic             stb,
  output logic             pulse_in,
  output logic             busy,
  output logic             done,
  output logic [4:0]       err_map,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N-1:0]     last_obs
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_SAMPLE, S_NEXT, S_DONE} state_t;

  state_t           state;
  logic             start_q;
  logic [4:0]       mask_r;
  logic [CNT_W-1:0] settle_r, cnt;
  logic [N-1:0]     pattern_r;
  logic [2:0]       ch;

  // Returns {found, index} of the lowest set bit of m at or above 'from'.
  function automatic logic [3:0] find_ch(input logic [4:0] m, input int from);
    logic [3:0] r;
    r = '0;
    for (int k = 4; k >= 0; k--)
      if (m[k] && k >= from) r = {1'b1, 3'(k)};
    return r;
  endfunction

  function automatic logic [N-1:0] rotl(input logic [N-1:0] p, input logic [2:0] s);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[(i + int'(s)) % N] = p[i];
    return r;
  endfunction

  // Channel/word for the next LOAD: straight from the inputs on the start edge,
  // from the captured run settings afterwards.
  logic [3:0]   pick;
  logic [N-1:0] ld_word;
  always_comb begin
    pick    = '0;
    ld_word = '0;
    if (state == S_IDLE) begin
      pick    = find_ch(ch_mask, 0);
      ld_word = rotl(pattern, pick[2:0]);
    end else begin
      pick    = find_ch(mask_r, int'(ch) + 1);
      ld_word = rotl(pattern_r, pick[2:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      mask_r    <= '0;
      settle_r  <= '0;
      pattern_r <= '0;
      cnt       <= '0;
      ch        <= '0;
      sel       <= '0;
      data_drv  <= '0;
      trigger   <= 1'b0;
      stb       <= 1'b0;
      pulse_in  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_map   <= '0;
      err_cnt   <= '0;
      last_obs  <= '0;
    end else begin
      start_q  <= start;
      trigger  <= 1'b0;
      stb      <= 1'b0;
      pulse_in <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (start && !start_q) begin
            err_map   <= '0;
            err_cnt   <= '0;
            mask_r    <= ch_mask;
            settle_r  <= settle;
            pattern_r <= pattern;
            if (pick[3]) begin
              ch       <= pick[2:0];
              sel      <= pick[2:0];
              data_drv <= ld_word;
              trigger  <= 1'b1;
              stb      <= (pick[2:0] == 3'd3);
              pulse_in <= (pick[2:0] == 3'd4);
              busy     <= 1'b1;
              state    <= S_LOAD;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
          S_LOAD: begin
            cnt   <= (settle_r == '0) ? CNT_W'(1) : settle_r;
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (cnt <= CNT_W'(1)) state <= S_SAMPLE;
            else                  cnt   <= cnt - CNT_W'(1);
          end
          S_SAMPLE: begin
            last_obs <= obs;
            if (obs != data_drv) begin
              err_map[ch] <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            end
            state <= S_NEXT;
          end
          S_NEXT: begin
            if (pick[3]) begin
              ch       <= pick[2:0];
              sel      <= pick[2:0];
              data_drv <= ld_word;
              trigger  <= 1'b1;
              stb      <= (pick[2:0] == 3'd3);
              pulse_in <= (pick[2:0] == 3'd4);
              state    <= S_LOAD;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
          S_DONE: if (!start) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
